// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared types, constants and helpers for the bus terminals.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Terminal address type; every packet carries one in its top byte.
  typedef logic [7:0] bus_id_t;

  // Widest packet the destination helper can accept.
  localparam int MAX_PKT_W = 256;
  typedef logic [MAX_PKT_W-1:0] pkt_t;

  // Field positions for the default 16-bit packet.
  localparam int PCKG_SZ = 16;
  localparam int DEST_HI = PCKG_SZ - 1;
  localparam int DEST_LO = PCKG_SZ - 8;

  // Destination that every terminal accepts, its own id notwithstanding.
  localparam bus_id_t BCAST_ID = 8'hFF;

  // Extract the destination byte from a zero-extended packet of width sz.
  function automatic bus_id_t dest_of(input pkt_t pkt, input int sz);
    return bus_id_t'(pkt >> (sz - 8));
  endfunction

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : bus_fifo_mem
//  Description : Register-array storage with one write port and a registered
//                head output. Pointer and occupancy control live in the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_fifo_mem #(
  parameter int width = 16,
  parameter int depth = 8,
  parameter int aw    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    head_addr,
  input  logic             head_en,
  output logic [width-1:0] head
);

  logic [width-1:0] mem [depth];

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Head register loads the entry that will be at the front after this edge,
  // forwarding the write data when that entry is being written right now.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        head <= '0;
    else if (head_en) head <= (we && (waddr == head_addr)) ? wdata : mem[head_addr];
  end

endmodule : bus_fifo_mem
`default_nettype wire

// File: rtl/bus_src_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bus_src_fifo
//  Description : Per-terminal source FIFO feeding the parallel bus. Filters
//                self-addressed packets and keeps saturating drop counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_src_fifo
  import bus_pkg::*;
#(
  parameter int          pckg_sz = 16,
  parameter int          depth   = 8,
  parameter logic [7:0]  id      = 8'h00,
  parameter int          cnt_w   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  output logic                       full,
  output logic [$clog2(depth+1)-1:0] count,
  output logic [cnt_w-1:0]           ovf_cnt,
  output logic [cnt_w-1:0]           self_cnt
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [AW-1:0]    rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CW-1:0]    count_q, count_nxt;
  logic             pndng_q, full_q;
  logic [cnt_w-1:0] ovf_q, self_q;
  bus_id_t          dest;
  logic             is_self, do_push, do_pop, ovf_hit, self_hit;

  // Pointers run 0..depth-1 and wrap, so depth need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(depth - 1)) ? '0 : p + AW'(1);
  endfunction

  // Accept/drop decisions. A pop only counts when a packet is pending, which
  // lets a full FIFO take a push in the same cycle its head is consumed.
  always_comb begin
    dest     = dest_of(pkt_t'(D_push), pckg_sz);
    is_self  = (dest == id) && (dest != BCAST_ID);
    do_pop   = pop && pndng_q;
    do_push  = push && !is_self && (!full_q || pop);
    ovf_hit  = push && !is_self && full_q && !pop;
    self_hit = push && is_self;
    rd_nxt   = do_pop  ? ptr_inc(rd_ptr) : rd_ptr;
    wr_nxt   = do_push ? ptr_inc(wr_ptr) : wr_ptr;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Occupancy state and flags, all registered from the next-state values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      pndng_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      rd_ptr  <= rd_nxt;
      wr_ptr  <= wr_nxt;
      count_q <= count_nxt;
      pndng_q <= (count_nxt != '0);
      full_q  <= (count_nxt == CW'(depth));
    end
  end

  // Drop statistics, held at all-ones once they get there.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q  <= '0;
      self_q <= '0;
    end else begin
      if (ovf_hit  && (ovf_q  != '1)) ovf_q  <= ovf_q  + cnt_w'(1);
      if (self_hit && (self_q != '1)) self_q <= self_q + cnt_w'(1);
    end
  end

  bus_fifo_mem #(
    .width (pckg_sz),
    .depth (depth),
    .aw    (AW)
  ) u_mem (
    .clock     (clock),
    .reset     (reset),
    .we        (do_push),
    .waddr     (wr_ptr),
    .wdata     (D_push),
    .head_addr (rd_nxt),
    .head_en   (count_nxt != '0),
    .head      (D_pop)
  );

  assign pndng    = pndng_q;
  assign full     = full_q;
  assign count    = count_q;
  assign ovf_cnt  = ovf_q;
  assign self_cnt = self_q;

endmodule : bus_src_fifo
`default_nettype wire
